// File: rtl/rf_scoreboard_if.sv
// Register-file / scoreboard signal bundle: read ports, write-back and issue handshake.
// Latency: none of its own; it only carries signals between the pipeline and rf_scoreboard.
// Backpressure: iss_ready is the only stall signal; write-back is never refused.
interface rf_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rR1;
    logic [AW-1:0]   rR2;
    logic [XLEN-1:0] rD1;
    logic [XLEN-1:0] rD2;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [1:0]      wD_sel;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] dram_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] wD;
    logic            iss_valid;
    logic            iss_rs1_used;
    logic            iss_rs2_used;
    logic [AW-1:0]   iss_rd;
    logic            iss_rd_used;
    logic            iss_ready;
    logic [AW:0]     busy_cnt;

    // Pipeline side: drives addresses, write-back data and issue requests.
    modport master (
        output rR1, rR2, wb_valid, wb_addr, wD_sel, alu_result, dram_data, imm, pc4,
               iss_valid, iss_rs1_used, iss_rs2_used, iss_rd, iss_rd_used,
        input  rD1, rD2, wD, iss_ready, busy_cnt
    );

    // Register-file side.
    modport slave (
        input  rR1, rR2, wb_valid, wb_addr, wD_sel, alu_result, dram_data, imm, pc4,
               iss_valid, iss_rs1_used, iss_rs2_used, iss_rd, iss_rd_used,
        output rD1, rD2, wD, iss_ready, busy_cnt
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Register file with per-register busy scoreboard; r0 is hardwired zero. Option macro: RF_BYPASS_EN (write-back to read forwarding).
// Latency: reads, wD and iss_ready are combinational; writes, busy bits and busy_cnt update on the next rising clk.
// Backpressure: iss_ready drops on a RAW (source) or WAW hazard; write-back always completes.
module rf_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_scoreboard_if.slave sb
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_busy_cnt;

    logic [XLEN-1:0] w_wd;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic            w_byp1;
    logic            w_byp2;
    logic            w_haz_rs1;
    logic            w_haz_rs2;
    logic            w_haz_waw;
    logic            w_ready;
    logic            w_issue;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_busy_pop;

    // Write-data source selection.
    always_comb begin
        w_wd = sb.alu_result;
        case (sb.wD_sel)
            2'b00:   w_wd = sb.alu_result;
            2'b01:   w_wd = sb.dram_data;
            2'b10:   w_wd = sb.imm;
            default: w_wd = sb.pc4;
        endcase
    end

    // Combinational reads; r0 masked to zero, optional forwarding of the in-flight write-back.
    always_comb begin
        w_rd1 = (sb.rR1 == '0) ? '0 : r_regs[sb.rR1];
        w_rd2 = (sb.rR2 == '0) ? '0 : r_regs[sb.rR2];
`ifdef RF_BYPASS_EN
        w_byp1 = sb.wb_valid && (sb.wb_addr == sb.rR1) && (sb.rR1 != '0);
        w_byp2 = sb.wb_valid && (sb.wb_addr == sb.rR2) && (sb.rR2 != '0);
        if (w_byp1) w_rd1 = w_wd;
        if (w_byp2) w_rd2 = w_wd;
`else
        w_byp1 = 1'b0;
        w_byp2 = 1'b0;
`endif
    end

    // Hazard detection; a write-back landing this cycle always clears a WAW,
    // but only resolves a source hazard when its data can be forwarded.
    always_comb begin
        w_haz_rs1 = sb.iss_rs1_used && (sb.rR1 != '0) && r_busy[sb.rR1] && !w_byp1;
        w_haz_rs2 = sb.iss_rs2_used && (sb.rR2 != '0) && r_busy[sb.rR2] && !w_byp2;
        w_haz_waw = sb.iss_rd_used && (sb.iss_rd != '0) && r_busy[sb.iss_rd]
                    && !(sb.wb_valid && (sb.wb_addr == sb.iss_rd));
        w_ready   = !(w_haz_rs1 || w_haz_rs2 || w_haz_waw);
        w_issue   = sb.iss_valid && w_ready;
    end

    // Next busy vector: clear on write-back first, then set on issue so a same-register set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (sb.wb_valid) w_busy_nxt[sb.wb_addr] = 1'b0;
        if (w_issue && sb.iss_rd_used && (sb.iss_rd != '0)) w_busy_nxt[sb.iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Population count of the next busy vector, registered so busy_cnt tracks r_busy exactly.
    always_comb begin
        w_busy_pop = '0;
        for (int i = 0; i < NREG; i++) begin
            w_busy_pop = w_busy_pop + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    // State update: reset discards any concurrent write-back or issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (sb.wb_valid && (sb.wb_addr != '0)) begin
                r_regs[sb.wb_addr] <= w_wd;
            end
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_pop;
        end
    end

    assign sb.wD        = w_wd;
    assign sb.rD1       = w_rd1;
    assign sb.rD2       = w_rd2;
    assign sb.iss_ready = w_ready;
    assign sb.busy_cnt  = r_busy_cnt;

endmodule
